// File: rtl/fifo.sv
// Synchronous first-word-fall-through FIFO with registered full/empty flags.
// Storage, pointers and flags clear asynchronously when rst is low.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      wptr_nxt;
  logic [PTR_W-1:0]      rptr_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  // Acceptance is judged against the flags as they stand before the edge,
  // so a push into a full FIFO is refused even if a pop frees a slot.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;

  // DEPTH is a power of two, so natural overflow of the pointer is the wrap.
  assign wptr_nxt = wptr + PTR_W'(1);
  assign rptr_nxt = rptr + PTR_W'(1);

  assign pop_data = mem[rptr];

  // NOTE: the storage array is reset on purpose so that pop_data reads zero
  // during and after reset; this costs a reset net on every storage bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok) begin
      // NOTE: non-blocking assignments keep every register update in this
      // design reading pre-edge values, matching the flop behaviour.
      mem[wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr_nxt;
      if (pop_ok)  rptr <= rptr_nxt;
    end
  end

  // Flags only move when exactly one side is accepted; a simultaneous
  // push and pop leaves occupancy, and therefore both flags, unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          full  <= (wptr_nxt == rptr);
          empty <= 1'b0;
        end
        2'b01: begin
          empty <= (rptr_nxt == wptr);
          full  <= 1'b0;
        end
        default: begin
          full  <= full;
          empty <= empty;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference of the FIFO's occupancy rules.
module tb_fifo;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  push = 1'b0;
  logic                  pop = 1'b0;
  logic [DATA_WIDTH-1:0] push_data = '0;
  logic [DATA_WIDTH-1:0] pop_data;
  logic                  full;
  logic                  empty;

  int checks = 0;
  int errors = 0;

  logic [DATA_WIDTH-1:0] model_q [$];

  fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  // Apply one cycle of inputs, let the edge pass, then advance the model.
  task automatic drive_cycle(input logic p, input logic pp, input logic [DATA_WIDTH-1:0] d);
    logic push_acc;
    logic pop_acc;
    push = p;
    pop = pp;
    push_data = d;
    push_acc = p && (model_q.size() < DEPTH);
    pop_acc  = pp && (model_q.size() > 0);
    @(posedge clk);
    #1;
    if (pop_acc) void'(model_q.pop_front());
    if (push_acc) model_q.push_back(d);
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    push_data = 8'h3C;
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_async_empty got %b exp 1", empty); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++;
    if (pop_data !== 8'h00) begin errors++; $display("FAIL reset_pop_data got %h exp 00", pop_data); end
    push = 1'b0;
    pop = 1'b0;
    rst = 1'b1;
    model_q.delete();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, 1'b0, 8'(8'h61 + i));
      checks++;
      if (full !== (i >= 3)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i >= 3)); end
      checks++;
      if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b exp 0", i, empty); end
      checks++;
      if (pop_data !== 8'h61) begin errors++; $display("FAIL fill_head[%0d] got %h exp 61", i, pop_data); end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        checks++;
        if (pop_data !== 8'(8'h61 + i)) begin
          errors++; $display("FAIL drain_data[%0d] got %h exp %h", i, pop_data, 8'(8'h61 + i));
        end
      end
      drive_cycle(1'b0, 1'b1, 8'h00);
      checks++;
      if (empty !== (i >= 3)) begin errors++; $display("FAIL drain_empty[%0d] got %b exp %b", i, empty, (i >= 3)); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got %b exp 0", i, full); end
    end
  endtask

  task automatic test_pass_through();
    drive_cycle(1'b1, 1'b0, 8'hAA);
    checks++;
    if (pop_data !== 8'hAA) begin errors++; $display("FAIL pass_data got %h exp aa", pop_data); end
    checks++;
    if (empty !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL pass_flags got e=%b f=%b exp e=0 f=0", empty, full);
    end
  endtask

  task automatic test_simultaneous();
    logic [DATA_WIDTH-1:0] exp_head;
    exp_head = 8'hAA;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (pop_data !== exp_head) begin errors++; $display("FAIL simul_data[%0d] got %h exp %h", i, pop_data, exp_head); end
      drive_cycle(1'b1, 1'b1, 8'(i));
      exp_head = 8'(i);
      checks++;
      if (empty !== 1'b0 || full !== 1'b0) begin
        errors++; $display("FAIL simul_flags[%0d] got e=%b f=%b exp e=0 f=0", i, empty, full);
      end
    end
    checks++;
    if (model_q.size() != 1 || pop_data !== 8'h0F) begin
      errors++; $display("FAIL simul_final got %h exp 0f", pop_data);
    end
  endtask

  task automatic test_boundary();
    logic [DATA_WIDTH-1:0] head;
    for (int i = 0; i < DEPTH && model_q.size() < DEPTH; i++) drive_cycle(1'b1, 1'b0, 8'(8'hB0 + i));
    checks++;
    if (full !== 1'b1) begin errors++; $display("FAIL bnd_full_set got %b exp 1", full); end
    head = model_q[0];
    drive_cycle(1'b1, 1'b1, 8'hEE);
    checks++;
    if (full !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL bnd_full_pushpop got f=%b e=%b exp f=0 e=0", full, empty);
    end
    checks++;
    if (model_q.size() != DEPTH - 1 || pop_data === head) begin
      errors++; $display("FAIL bnd_full_advance got %h exp not %h", pop_data, head);
    end
    for (int i = 0; i < 2 * DEPTH && model_q.size() > 0; i++) begin
      checks++;
      if (pop_data !== model_q[0]) begin errors++; $display("FAIL bnd_drain[%0d] got %h exp %h", i, pop_data, model_q[0]); end
      drive_cycle(1'b0, 1'b1, 8'h00);
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL bnd_drained got %b exp 1", empty); end
    drive_cycle(1'b1, 1'b1, 8'h5C);
    checks++;
    if (empty !== 1'b0 || pop_data !== 8'h5C) begin
      errors++; $display("FAIL bnd_empty_pushpop got e=%b d=%h exp e=0 d=5c", empty, pop_data);
    end
    drive_cycle(1'b1, 1'b0, 8'h71);
    drive_cycle(1'b1, 1'b0, 8'h72);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || pop_data !== 8'h00) begin
      errors++; $display("FAIL bnd_mid_reset got e=%b f=%b d=%h exp e=1 f=0 d=00", empty, full, pop_data);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_q.delete();
    @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1 || pop_data !== 8'h00) begin
      errors++; $display("FAIL bnd_post_reset got e=%b d=%h exp e=1 d=00", empty, pop_data);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (full !== (model_q.size() == DEPTH) || empty !== (model_q.size() == 0)) begin
        errors++;
        $display("FAIL rand_flags[%0d] got f=%b e=%b exp f=%b e=%b", i, full, empty,
                 (model_q.size() == DEPTH), (model_q.size() == 0));
      end
      if (model_q.size() > 0) begin
        checks++;
        if (pop_data !== model_q[0]) begin
          errors++; $display("FAIL rand_data[%0d] got %h exp %h", i, pop_data, model_q[0]);
        end
      end
      drive_cycle(1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_pass_through();
    test_simultaneous();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have a parameter DATA_WIDTH, default 8, that sets the width of the push and pop data words.
REQ-002 The module SHALL have a parameter DEPTH, default 4, that sets the number of entries; DEPTH SHALL be a power of two and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port push, input, 1 bit: write request, sampled on the rising edge of clk.
REQ-006 The module SHALL have port pop, input, 1 bit: read request, sampled on the rising edge of clk.
REQ-007 The module SHALL have port push_data, input, DATA_WIDTH bits: the word to write.
REQ-008 The module SHALL have port pop_data, output, DATA_WIDTH bits: the word at the head of the queue.
REQ-009 The module SHALL have port full, output, 1 bit: high when the FIFO holds DEPTH entries.
REQ-010 The module SHALL have port empty, output, 1 bit: high when the FIFO holds 0 entries.

Function
REQ-011 The storage SHALL be DEPTH words of DATA_WIDTH bits, with a write pointer and a read pointer of log2(DEPTH) bits each; both pointers SHALL wrap modulo DEPTH.
REQ-012 A push SHALL be accepted iff push=1 and full=0 at the clock edge; the FIFO SHALL then write mem[wptr] <= push_data and increment wptr.
REQ-013 A pop SHALL be accepted iff pop=1 and empty=0 at the clock edge; the FIFO SHALL then increment rptr.
REQ-014 pop_data SHALL be combinational, equal to mem[rptr] (first-word-fall-through), valid whenever empty=0, before the accepting edge, with zero-cycle read latency.
REQ-015 Acceptance of push and acceptance of pop SHALL be evaluated independently, each against the full/empty value present before the edge.
REQ-016 When both push and pop are accepted, both pointers SHALL advance and the occupancy, full and empty SHALL remain unchanged.
REQ-017 When full=1 and push=pop=1, only the pop SHALL take effect; full SHALL fall to 0 and push_data SHALL be discarded.
REQ-018 When empty=1 and push=pop=1, only the push SHALL take effect; empty SHALL fall to 0 and the new word SHALL appear on pop_data after the edge.
REQ-019 A push while full SHALL leave memory, pointers and flags unchanged; a pop while empty SHALL leave memory, pointers and flags unchanged.
REQ-020 full and empty SHALL be registered outputs, updated on the same edge as the pointers.
REQ-021 After a push-only, full SHALL be set iff the next wptr equals rptr; empty SHALL clear.
REQ-022 After a pop-only, empty SHALL be set iff the next rptr equals wptr; full SHALL clear.
REQ-023 full and empty SHALL never be 1 simultaneously.
REQ-024 Data SHALL leave the FIFO in strict first-in, first-out order across any number of pointer wraps.

Reset
REQ-025 rst=0 SHALL immediately, independent of clk, set wptr=0, rptr=0, full=0 and empty=1.
REQ-026 rst=0 SHALL immediately clear every memory word to 0, so that pop_data=0 during and after reset.
REQ-027 An assertion of rst in mid-operation SHALL discard all stored contents.
REQ-028 While rst=0, push and pop SHALL be ignored.
REQ-029 The FIFO SHALL be operational on the first rising edge after rst returns to 1.

Verification
REQ-030 Fill: after reset, push 0x61..0x65 on 5 consecutive cycles -> full=1 after the 4th push; 0x65 dropped; empty=0.
REQ-031 Drain: then pop 5 consecutive cycles -> pop_data reads 0x61, 0x62, 0x63, 0x64 before each accepting edge; empty=1 after the 4th pop; the 5th pop has no effect.
REQ-032 Pass-through: push 0xAA once -> pop_data=0xAA the following cycle, with empty=0 and full=0.
REQ-033 Simultaneous: for 16 cycles assert push=pop=1 with push_data=0..15 -> occupancy stays 1, pop_data lags push_data by one word, and the pointers wrap 4 times without a flag change.
REQ-034 Boundary: full plus push and pop -> full=0, no write; empty plus push and pop -> empty=0, word stored; reset asserted with 3 entries stored -> empty=1, pop_data=0 asynchronously.
REQ-035 Random: 256 cycles of random push, pop and data checked against a DEPTH-entry reference queue -> zero mismatches.
